// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Round-sequencing FSM for an AES datapath. It orders AddRoundKey, (Inv)SubBytes,
// (Inv)ShiftRows and (Inv)MixColumns for encrypt or decrypt, with an optional
// key-expansion phase before the rounds. It drives the step select (o_cs), the
// round-key index (o_rnd) and the key-expansion index (o_kidx). It carries no data.

module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic       i_key_new,
  input  logic       i_abort,
  output logic [2:0] o_cs,
  output logic [3:0] o_rnd,
  output logic [3:0] o_kidx,
  output logic       o_busy,
  output logic       o_done
);

  // Only the three AES key sizes have a meaningful round count.
  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] NR_C      = 4'(NR);
  localparam logic [3:0] KIDX_LAST = 4'(NR - 1);
  localparam logic [3:0] ZERO4     = 4'd0;
  localparam logic [3:0] ONE4      = 4'd1;

  // The codes are visible on o_cs, so each value is pinned explicitly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_ADD  = 3'b010,
    ST_SUB  = 3'b011,
    ST_SHI  = 3'b100,
    ST_MIX  = 3'b101,
    ST_KEXP = 3'b110,
    ST_DONE = 3'b111
  } state_e;

  state_e     r_state;
  logic [3:0] r_rnd;
  logic [3:0] r_kidx;
  logic       r_mode;
  logic       r_key_new;
  logic       r_busy;
  logic       r_done;

  state_e     w_state_nxt;
  logic [3:0] w_rnd_nxt;
  logic [3:0] w_kidx_nxt;
  logic       w_mode_nxt;
  logic       w_key_new_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  // busy covers every working step. It excludes IDLE and the DONE handshake cycle.
  function automatic logic f_is_busy(input state_e s);
    logic b;
    case (s)
      ST_LOAD, ST_ADD, ST_SUB, ST_SHI, ST_MIX, ST_KEXP: b = 1'b1;
      default:                                          b = 1'b0;
    endcase
    return b;
  endfunction

  // Next-state, round-index and key-index logic. Every target holds unless a step moves it.
  always_comb begin
    w_state_nxt   = r_state;
    w_rnd_nxt     = r_rnd;
    w_kidx_nxt    = r_kidx;
    w_mode_nxt    = r_mode;
    w_key_new_nxt = r_key_new;

    if ((r_state != ST_IDLE) && i_abort) begin
      // Abort drops the operation at once. done never pulses for it.
      w_state_nxt = ST_IDLE;
      w_rnd_nxt   = ZERO4;
      w_kidx_nxt  = ZERO4;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            w_mode_nxt    = i_mode;
            w_key_new_nxt = i_key_new;
            w_kidx_nxt    = ZERO4;
            w_state_nxt   = i_key_new ? ST_KEXP : ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_KEXP: begin
          // One expansion round per cycle. kidx is left at 0 for the next use.
          if ((r_kidx == KIDX_LAST) || !r_key_new) begin
            w_kidx_nxt  = ZERO4;
            w_state_nxt = ST_LOAD;
          end else begin
            w_kidx_nxt  = r_kidx + ONE4;
            w_state_nxt = ST_KEXP;
          end
        end

        ST_LOAD: begin
          // Encrypt consumes round keys upward from 0. Decrypt consumes them downward from NR.
          w_rnd_nxt   = r_mode ? NR_C : ZERO4;
          w_state_nxt = ST_ADD;
        end

        ST_ADD: begin
          if (!r_mode) begin
            if (r_rnd == NR_C) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_rnd_nxt   = r_rnd + ONE4;
              w_state_nxt = ST_SUB;
            end
          end else begin
            if (r_rnd == ZERO4) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_rnd_nxt = r_rnd - ONE4;
              // The first inverse round has no InvMixColumns.
              if (r_rnd == NR_C) begin
                w_state_nxt = ST_SHI;
              end else begin
                w_state_nxt = ST_MIX;
              end
            end
          end
        end

        ST_SUB: begin
          w_state_nxt = r_mode ? ST_ADD : ST_SHI;
        end

        ST_SHI: begin
          if (r_mode) begin
            w_state_nxt = ST_SUB;
          end else if (r_rnd == NR_C) begin
            // The final forward round skips MixColumns.
            w_state_nxt = ST_ADD;
          end else begin
            w_state_nxt = ST_MIX;
          end
        end

        ST_MIX: begin
          w_state_nxt = r_mode ? ST_SHI : ST_ADD;
        end

        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_rnd_nxt   = ZERO4;
          w_kidx_nxt  = ZERO4;
        end
      endcase
    end

    w_busy_nxt = f_is_busy(w_state_nxt);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // State and index registers. busy/done are registered from the next state so they track cs exactly.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state   <= ST_IDLE;
      r_rnd     <= ZERO4;
      r_kidx    <= ZERO4;
      r_mode    <= 1'b0;
      r_key_new <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rnd     <= w_rnd_nxt;
      r_kidx    <= w_kidx_nxt;
      r_mode    <= w_mode_nxt;
      r_key_new <= w_key_new_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_cs   = r_state;
  assign o_rnd  = r_rnd;
  assign o_kidx = r_kidx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl. It runs three instances (NR = 10, 12, 14).
// Observed step traces are compared against a round-level reference model.

module tb_aes_round_ctrl;

  localparam int C_IDLE = 0, C_LOAD = 1, C_ADD = 2, C_SUB = 3;
  localparam int C_SHI  = 4, C_MIX  = 5, C_KEXP = 6, C_DONE = 7;

  logic       clk = 1'b0;
  logic       res, mode, key_new, abort;
  logic [2:0] start_v;
  logic [2:0] cs_w   [3];
  logic [3:0] rnd_w  [3];
  logic [3:0] kidx_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int nr_of [3] = '{10, 12, 14};

  // Observed trace, one entry per cycle.
  logic [2:0] o_cs_q[$];
  logic [3:0] o_rnd_q[$];
  logic [3:0] o_kidx_q[$];
  logic       o_busy_q[$];
  logic       o_done_q[$];
  // Expected trace. An rnd of -1 means "not defined in this step".
  int e_cs_q[$];
  int e_rnd_q[$];
  int e_kidx_q[$];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) u_dut10 (
    .i_clk(clk), .i_res(res), .i_start(start_v[0]), .i_mode(mode), .i_key_new(key_new),
    .i_abort(abort), .o_cs(cs_w[0]), .o_rnd(rnd_w[0]), .o_kidx(kidx_w[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]));

  aes_round_ctrl #(.NR(12)) u_dut12 (
    .i_clk(clk), .i_res(res), .i_start(start_v[1]), .i_mode(mode), .i_key_new(key_new),
    .i_abort(abort), .o_cs(cs_w[1]), .o_rnd(rnd_w[1]), .o_kidx(kidx_w[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]));

  aes_round_ctrl #(.NR(14)) u_dut14 (
    .i_clk(clk), .i_res(res), .i_start(start_v[2]), .i_mode(mode), .i_key_new(key_new),
    .i_abort(abort), .o_cs(cs_w[2]), .o_rnd(rnd_w[2]), .o_kidx(kidx_w[2]),
    .o_busy(busy_w[2]), .o_done(done_w[2]));

  task automatic push_exp(input int c, input int r, input int k);
    e_cs_q.push_back(c);
    e_rnd_q.push_back(r);
    e_kidx_q.push_back(k);
  endtask

  // Reference model: expand the round structure of one operation into per-cycle steps.
  task automatic build_model(input int nr, input bit m, input bit kn);
    e_cs_q.delete(); e_rnd_q.delete(); e_kidx_q.delete();
    if (kn) for (int k = 0; k < nr; k++) push_exp(C_KEXP, -1, k);
    push_exp(C_LOAD, -1, 0);
    if (!m) begin
      push_exp(C_ADD, 0, 0);
      for (int r = 1; r <= nr; r++) begin
        push_exp(C_SUB, r, 0);
        push_exp(C_SHI, r, 0);
        if (r < nr) push_exp(C_MIX, r, 0);
        push_exp(C_ADD, r, 0);
      end
    end else begin
      push_exp(C_ADD, nr, 0);
      for (int r = nr - 1; r >= 0; r--) begin
        if (r < nr - 1) push_exp(C_MIX, r, 0);
        push_exp(C_SHI, r, 0);
        push_exp(C_SUB, r, 0);
        push_exp(C_ADD, r, 0);
      end
    end
    push_exp(C_DONE, m ? 0 : nr, 0);
    push_exp(C_IDLE, m ? 0 : nr, 0);
  endtask

  // Cut the model after step k, where abort is raised. IDLE with cleared indices follows.
  task automatic abort_model(input int k, input int tail);
    e_cs_q = e_cs_q[0:k]; e_rnd_q = e_rnd_q[0:k]; e_kidx_q = e_kidx_q[0:k];
    for (int t = 0; t < tail; t++) push_exp(C_IDLE, 0, 0);
  endtask

  // Start one operation on instance s and record n cycles. Optionally perturb start/mode/key_new or raise abort.
  task automatic capture(input int s, input logic m, input logic kn, input bit perturb,
                         input int abort_at, input int n);
    o_cs_q.delete(); o_rnd_q.delete(); o_kidx_q.delete(); o_busy_q.delete(); o_done_q.delete();
    start_v = 3'b000; start_v[s] = 1'b1; mode = m; key_new = kn; abort = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      o_cs_q.push_back(cs_w[s]);     o_rnd_q.push_back(rnd_w[s]);
      o_kidx_q.push_back(kidx_w[s]); o_busy_q.push_back(busy_w[s]);
      o_done_q.push_back(done_w[s]);
      start_v = 3'b000; abort = 1'b0;
      if (perturb && (k < n - 1)) begin
        start_v[s] = 1'($urandom_range(0, 1));
        mode       = 1'($urandom_range(0, 1));
        key_new    = 1'($urandom_range(0, 1));
      end
      if (k == abort_at) abort = 1'b1;
    end
    start_v = 3'b000; abort = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b1; start_v = 3'b000; abort = 1'b0; mode = 1'b0; key_new = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total_cnt++;
      if ({cs_w[d], rnd_w[d], kidx_w[d], busy_w[d], done_w[d]} !== 13'd0)
        $display("FAIL reset_init[%0d] cs/rnd/kidx/busy/done got %0d/%0d/%0d/%0b/%0b want 0/0/0/0/0",
                 d, cs_w[d], rnd_w[d], kidx_w[d], busy_w[d], done_w[d]);
      else pass_cnt++;
    end
    @(negedge clk); res = 1'b0;
    // Run NR=10 into its rounds and NR=14 into key expansion, then reset mid-sequence.
    start_v = 3'b101; mode = 1'b0; key_new = 1'b1;
    @(negedge clk); start_v = 3'b000;
    repeat (13) @(negedge clk);
    res = 1'b1; start_v = 3'b111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total_cnt++;
        if ({cs_w[d], rnd_w[d], kidx_w[d], busy_w[d], done_w[d]} !== 13'd0)
          $display("FAIL reset_mid[%0d.%0d] cs/rnd/kidx/busy/done got %0d/%0d/%0d/%0b/%0b want 0/0/0/0/0",
                   c, d, cs_w[d], rnd_w[d], kidx_w[d], busy_w[d], done_w[d]);
        else pass_cnt++;
      end
    end
    res = 1'b0; start_v = 3'b000; key_new = 1'b0;
  endtask

  task automatic test_sequences;
    int  sc_sel [6] = '{0, 0, 2, 1, 1, 2};
    bit  sc_m   [6] = '{0, 1, 0, 0, 1, 1};
    bit  sc_kn  [6] = '{0, 1, 0, 0, 0, 1};
    int  s, first, cnt, want;
    bit  m, kn, eb;
    string nm;
    for (int it = 0; it < 10; it++) begin
      if (it < 6) begin
        s = sc_sel[it]; m = sc_m[it]; kn = sc_kn[it];
      end else begin
        s = int'($urandom_range(0, 2)); m = 1'($urandom_range(0, 1)); kn = 1'($urandom_range(0, 1));
      end
      nm = $sformatf("seq%0d_nr%0d_m%0d_k%0d", it, nr_of[s], m, kn);
      build_model(nr_of[s], m, kn);
      capture(s, m, kn, 1'b0, -1, e_cs_q.size());
      for (int i = 0; i < e_cs_q.size(); i++) begin
        eb = (e_cs_q[i] != C_IDLE) && (e_cs_q[i] != C_DONE);
        total_cnt++; if (o_cs_q[i] !== 3'(e_cs_q[i])) $display("FAIL %s[%0d] cs got %0d want %0d", nm, i, o_cs_q[i], e_cs_q[i]); else pass_cnt++;
        if (e_rnd_q[i] >= 0) begin
          total_cnt++; if (o_rnd_q[i] !== 4'(e_rnd_q[i])) $display("FAIL %s[%0d] rnd got %0d want %0d", nm, i, o_rnd_q[i], e_rnd_q[i]); else pass_cnt++;
        end
        total_cnt++; if (o_kidx_q[i] !== 4'(e_kidx_q[i])) $display("FAIL %s[%0d] kidx got %0d want %0d", nm, i, o_kidx_q[i], e_kidx_q[i]); else pass_cnt++;
        total_cnt++; if (o_busy_q[i] !== eb) $display("FAIL %s[%0d] busy got %0b want %0b", nm, i, o_busy_q[i], eb); else pass_cnt++;
        total_cnt++; if (o_done_q[i] !== (e_cs_q[i] == C_DONE)) $display("FAIL %s[%0d] done got %0b want %0b", nm, i, o_done_q[i], e_cs_q[i] == C_DONE); else pass_cnt++;
      end
      // done must be a single pulse at edge 4*NR+2, shifted by NR when key expansion runs first.
      first = -1; cnt = 0;
      for (int j = 0; j < o_done_q.size(); j++) if (o_done_q[j] === 1'b1) begin cnt++; if (first < 0) first = j; end
      want = 4 * nr_of[s] + 2 + (kn ? nr_of[s] : 0);
      total_cnt++;
      if ((first + 1 != want) || (cnt != 1))
        $display("FAIL %s done_edge got edge %0d (pulses %0d) want edge %0d (pulses 1)", nm, first + 1, cnt, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort;
    int  s, k;
    bit  m, kn, eb;
    string nm;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        s = 0; m = 1'b0; kn = 1'b0; k = 20;
      end else if (it < 4) begin
        s = int'($urandom_range(0, 2)); m = 1'($urandom_range(0, 1)); kn = 1'($urandom_range(0, 1));
        build_model(nr_of[s], m, kn);
        k = int'($urandom_range(0, e_cs_q.size() - 2));
      end else begin
        s = 0; m = 1'b0; kn = 1'b0; k = -1;
      end
      nm = $sformatf("abort%0d_nr%0d_m%0d_k%0d_at%0d", it, nr_of[s], m, kn, k);
      build_model(nr_of[s], m, kn);
      if (k >= 0) abort_model(k, 4);
      capture(s, m, kn, 1'b0, k, e_cs_q.size());
      if (it == 0) begin
        total_cnt++;
        if ((o_cs_q[20] !== 3'(C_MIX)) || (o_rnd_q[20] !== 4'd5))
          $display("FAIL abort_point cs/rnd got %0d/%0d want %0d/5", o_cs_q[20], o_rnd_q[20], C_MIX);
        else pass_cnt++;
      end
      for (int i = 0; i < e_cs_q.size(); i++) begin
        eb = (e_cs_q[i] != C_IDLE) && (e_cs_q[i] != C_DONE);
        total_cnt++; if (o_cs_q[i] !== 3'(e_cs_q[i])) $display("FAIL %s[%0d] cs got %0d want %0d", nm, i, o_cs_q[i], e_cs_q[i]); else pass_cnt++;
        if (e_rnd_q[i] >= 0) begin
          total_cnt++; if (o_rnd_q[i] !== 4'(e_rnd_q[i])) $display("FAIL %s[%0d] rnd got %0d want %0d", nm, i, o_rnd_q[i], e_rnd_q[i]); else pass_cnt++;
        end
        total_cnt++; if (o_kidx_q[i] !== 4'(e_kidx_q[i])) $display("FAIL %s[%0d] kidx got %0d want %0d", nm, i, o_kidx_q[i], e_kidx_q[i]); else pass_cnt++;
        total_cnt++; if (o_busy_q[i] !== eb) $display("FAIL %s[%0d] busy got %0b want %0b", nm, i, o_busy_q[i], eb); else pass_cnt++;
        total_cnt++; if (o_done_q[i] !== (e_cs_q[i] == C_DONE)) $display("FAIL %s[%0d] done got %0b want %0b", nm, i, o_done_q[i], e_cs_q[i] == C_DONE); else pass_cnt++;
      end
    end
  endtask

  task automatic test_misuse;
    bit  m, kn, eb;
    string nm;
    // start pulses and mode/key_new toggles while running must not disturb the trace.
    for (int it = 0; it < 2; it++) begin
      m = 1'(it); kn = 1'($urandom_range(0, 1));
      nm = $sformatf("misuse%0d_m%0d_k%0d", it, m, kn);
      build_model(10, m, kn);
      capture(0, m, kn, 1'b1, -1, e_cs_q.size());
      for (int i = 0; i < e_cs_q.size(); i++) begin
        eb = (e_cs_q[i] != C_IDLE) && (e_cs_q[i] != C_DONE);
        total_cnt++; if (o_cs_q[i] !== 3'(e_cs_q[i])) $display("FAIL %s[%0d] cs got %0d want %0d", nm, i, o_cs_q[i], e_cs_q[i]); else pass_cnt++;
        if (e_rnd_q[i] >= 0) begin
          total_cnt++; if (o_rnd_q[i] !== 4'(e_rnd_q[i])) $display("FAIL %s[%0d] rnd got %0d want %0d", nm, i, o_rnd_q[i], e_rnd_q[i]); else pass_cnt++;
        end
        total_cnt++; if (o_kidx_q[i] !== 4'(e_kidx_q[i])) $display("FAIL %s[%0d] kidx got %0d want %0d", nm, i, o_kidx_q[i], e_kidx_q[i]); else pass_cnt++;
        total_cnt++; if (o_busy_q[i] !== eb) $display("FAIL %s[%0d] busy got %0b want %0b", nm, i, o_busy_q[i], eb); else pass_cnt++;
        total_cnt++; if (o_done_q[i] !== (e_cs_q[i] == C_DONE)) $display("FAIL %s[%0d] done got %0b want %0b", nm, i, o_done_q[i], e_cs_q[i] == C_DONE); else pass_cnt++;
      end
    end
    // start and abort together in IDLE: nothing starts.
    start_v = 3'b111; abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total_cnt++;
        if ((cs_w[d] !== 3'(C_IDLE)) || (busy_w[d] !== 1'b0))
          $display("FAIL start_abort_idle[%0d.%0d] cs/busy got %0d/%0b want %0d/0", c, d, cs_w[d], busy_w[d], C_IDLE);
        else pass_cnt++;
      end
    end
    start_v = 3'b000; abort = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit  m, eb;
    string nm;
    // Each capture starts right after the previous IDLE sample, with exactly one IDLE cycle between ops.
    for (int it = 0; it < 3; it++) begin
      m = 1'(it % 2);
      nm = $sformatf("b2b%0d_m%0d", it, m);
      build_model(12, m, 1'(it == 1));
      capture(1, m, 1'(it == 1), 1'b0, -1, e_cs_q.size());
      for (int i = 0; i < e_cs_q.size(); i++) begin
        eb = (e_cs_q[i] != C_IDLE) && (e_cs_q[i] != C_DONE);
        total_cnt++; if (o_cs_q[i] !== 3'(e_cs_q[i])) $display("FAIL %s[%0d] cs got %0d want %0d", nm, i, o_cs_q[i], e_cs_q[i]); else pass_cnt++;
        if (e_rnd_q[i] >= 0) begin
          total_cnt++; if (o_rnd_q[i] !== 4'(e_rnd_q[i])) $display("FAIL %s[%0d] rnd got %0d want %0d", nm, i, o_rnd_q[i], e_rnd_q[i]); else pass_cnt++;
        end
        total_cnt++; if (o_kidx_q[i] !== 4'(e_kidx_q[i])) $display("FAIL %s[%0d] kidx got %0d want %0d", nm, i, o_kidx_q[i], e_kidx_q[i]); else pass_cnt++;
        total_cnt++; if (o_busy_q[i] !== eb) $display("FAIL %s[%0d] busy got %0b want %0b", nm, i, o_busy_q[i], eb); else pass_cnt++;
        total_cnt++; if (o_done_q[i] !== (e_cs_q[i] == C_DONE)) $display("FAIL %s[%0d] done got %0b want %0b", nm, i, o_done_q[i], e_cs_q[i] == C_DONE); else pass_cnt++;
      end
    end
  endtask

  initial begin
    res = 1'b1; start_v = 3'b000; mode = 1'b0; key_new = 1'b0; abort = 1'b0;
    test_reset();
    test_sequences();
    test_abort();
    test_misuse();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
